// File: rtl/idli_cmp_m.sv
// rtl/idli_cmp_m.sv - bit-serial compare unit writing condition results into the predicate register file.
module idli_cmp_m #(
    parameter int WIDTH = 16
) (
    input  logic       i_cmp_gck,
    input  logic       i_cmp_rst_n,
    input  logic       i_cmp_start,
    input  logic [2:0] i_cmp_op,
    input  logic [1:0] i_cmp_dst,
    input  logic       i_cmp_a,
    input  logic       i_cmp_b,
    output logic       o_cmp_busy,
    output logic [1:0] o_cmp_q,
    output logic       o_cmp_q_wr_en,
    output logic       o_cmp_q_data
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    op_q;
    logic [1:0]    dst_q;
    logic          eq_q;
    logic          lt_q;
    logic          res_q;

    logic          bit_diff;
    logic          eq_d;
    logic          lt_d;
    logic          ltu_final;
    logic          lts_final;
    logic          res_d;

    assign bit_diff = i_cmp_a ^ i_cmp_b;

    // On the MSB the sign bit reverses the unsigned sense: a set A sign bit means A is smaller.
    always_comb begin
        eq_d      = eq_q & ~bit_diff;
        lt_d      = bit_diff ? i_cmp_b : lt_q;
        ltu_final = lt_d;
        lts_final = bit_diff ? i_cmp_a : lt_q;
        case (op_q)
            3'd0:    res_d = eq_d;
            3'd1:    res_d = ~eq_d;
            3'd2:    res_d = lts_final;
            3'd3:    res_d = ltu_final;
            3'd4:    res_d = ~lts_final;
            3'd5:    res_d = ~ltu_final;
            default: res_d = 1'b0;
        endcase
    end

    always_ff @(posedge i_cmp_gck or negedge i_cmp_rst_n) begin
        if (!i_cmp_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= 3'd0;
            dst_q   <= 2'b00;
            eq_q    <= 1'b1;
            lt_q    <= 1'b0;
            res_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    eq_q <= eq_d;
                    lt_q <= lt_d;
                    if (cnt_q == LAST_BIT) begin
                        res_q   <= res_d;
                        cnt_q   <= '0;
                        state_q <= ST_WB;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    // IDLE and WB both accept a start; in WB the pending write still uses the old regs.
                    if (i_cmp_start) begin
                        op_q    <= i_cmp_op;
                        dst_q   <= i_cmp_dst;
                        eq_q    <= ~bit_diff;
                        lt_q    <= ~i_cmp_a & i_cmp_b;
                        cnt_q   <= CW'(1);
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign o_cmp_busy    = (state_q != ST_IDLE);
    assign o_cmp_q       = dst_q;
    assign o_cmp_q_data  = res_q;
    // Index 3 is the hardwired-true predicate and is never written.
    assign o_cmp_q_wr_en = (state_q == ST_WB) && (dst_q != 2'd3);

endmodule

// File: tb/tb_idli_cmp_m.sv
// tb/tb_idli_cmp_m.sv - randomized and directed self-checking bench for idli_cmp_m.
module tb_idli_cmp_m;

    localparam int W = 16;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] op;
    logic [1:0] dst;
    logic       a_bit;
    logic       b_bit;
    logic       busy;
    logic [1:0] q;
    logic       wr_en;
    logic       data;

    int vectors;
    int miscompares;

    idli_cmp_m #(.WIDTH(W)) dut (
        .i_cmp_gck     (clk),
        .i_cmp_rst_n   (rst_n),
        .i_cmp_start   (start),
        .i_cmp_op      (op),
        .i_cmp_dst     (dst),
        .i_cmp_a       (a_bit),
        .i_cmp_b       (b_bit),
        .o_cmp_busy    (busy),
        .o_cmp_q       (q),
        .o_cmp_q_wr_en (wr_en),
        .o_cmp_q_data  (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic ref_cmp(input logic [2:0] f_op, input logic [W-1:0] fa, input logic [W-1:0] fb);
        case (f_op)
            3'd0:    return fa == fb;
            3'd1:    return fa != fb;
            3'd2:    return $signed(fa) < $signed(fb);
            3'd3:    return fa < fb;
            3'd4:    return $signed(fa) >= $signed(fb);
            3'd5:    return fa >= fb;
            default: return 1'b0;
        endcase
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one compare from the current cycle (cycle 0) through cycle W+1 and reports what was seen.
    task automatic do_cmp(input logic [2:0] c_op, input logic [1:0] c_dst,
                          input logic [W-1:0] av, input logic [W-1:0] bv,
                          input int restart_at, input logic [2:0] alt_op, input logic [1:0] alt_dst,
                          output int wr_count, output logic wr_at_w, output logic data_w,
                          output logic [1:0] q_w, output int busy_errs, output logic busy_after);
        wr_count  = 0;
        busy_errs = 0;
        wr_at_w   = 1'b0;
        data_w    = 1'b0;
        q_w       = 2'b00;
        start = 1'b1; op = c_op; dst = c_dst; a_bit = av[0]; b_bit = bv[0];
        for (int k = 1; k <= W; k++) begin
            next_cycle();
            start = 1'b0;
            if (busy !== 1'b1) busy_errs++;
            if (wr_en === 1'b1) wr_count++;
            if (k == W) begin
                wr_at_w = wr_en;
                data_w  = data;
                q_w     = q;
            end
            if (k < W) begin
                a_bit = av[k];
                b_bit = bv[k];
            end else begin
                a_bit = 1'b0;
                b_bit = 1'b0;
            end
            if (k == restart_at) begin
                start = 1'b1; op = alt_op; dst = alt_dst;
            end
        end
        next_cycle();
        if (wr_en === 1'b1) wr_count++;
        busy_after = busy;
    endtask

    task automatic check_run(input string name, input logic [2:0] c_op, input logic [1:0] c_dst,
                             input logic [W-1:0] av, input logic [W-1:0] bv, input int restart_at);
        int wr_count, busy_errs;
        logic wr_at_w, data_w, busy_after;
        logic [1:0] q_w;
        logic exp_data;
        int exp_wr;
        exp_data = ref_cmp(c_op, av, bv);
        exp_wr   = (c_dst == 2'd3) ? 0 : 1;
        do_cmp(c_op, c_dst, av, bv, restart_at, 3'(~c_op), 2'(c_dst + 2'd1),
               wr_count, wr_at_w, data_w, q_w, busy_errs, busy_after);
        vectors++;
        if (data_w !== exp_data) begin
            miscompares++;
            $display("FAIL %s data: got %b want %b (op %0d a %h b %h)", name, data_w, exp_data, c_op, av, bv);
        end
        vectors++;
        if (wr_count !== exp_wr || wr_at_w !== (exp_wr == 1)) begin
            miscompares++;
            $display("FAIL %s wr_en: got count %0d at_w %b want count %0d", name, wr_count, wr_at_w, exp_wr);
        end
        vectors++;
        if (q_w !== c_dst) begin
            miscompares++;
            $display("FAIL %s q: got %0d want %0d", name, q_w, c_dst);
        end
        vectors++;
        if (busy_errs !== 0 || busy_after !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy: low cycles %0d, after %b want 0 and 0", name, busy_errs, busy_after);
        end
    endtask

    task automatic test_reset();
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b want 0", busy); end
        vectors++;
        if (wr_en !== 1'b0) begin miscompares++; $display("FAIL reset wr_en: got %b want 0", wr_en); end
        vectors++;
        if (q !== 2'b00) begin miscompares++; $display("FAIL reset q: got %b want 00", q); end
        vectors++;
        if (data !== 1'b0) begin miscompares++; $display("FAIL reset data: got %b want 0", data); end
    endtask

    task automatic test_directed();
        check_run("eq_match",   3'd0, 2'd0, 16'h1234, 16'h1234, -1);
        check_run("lt_sign",    3'd2, 2'd1, 16'h8000, 16'h0001, -1);
        check_run("ltu_sign",   3'd3, 2'd1, 16'h8000, 16'h0001, -1);
        check_run("geu_sign",   3'd5, 2'd1, 16'h8000, 16'h0001, -1);
        check_run("ge_sign",    3'd4, 2'd1, 16'h8000, 16'h0001, -1);
        check_run("ltu_ffff",   3'd3, 2'd2, 16'hFFFF, 16'hFFFF, -1);
        check_run("ne_ffff",    3'd1, 2'd2, 16'hFFFF, 16'hFFFF, -1);
        check_run("dst3_eq",    3'd0, 2'd3, 16'h0000, 16'h0000, -1);
        check_run("reserved6",  3'd6, 2'd0, 16'h0003, 16'h0007, -1);
        check_run("lt_lsb",     3'd3, 2'd0, 16'h0000, 16'h0001, -1);
    endtask

    task automatic test_random();
        logic [W-1:0] av, bv;
        for (int n = 0; n < 40; n++) begin
            av = W'($urandom);
            bv = ($urandom_range(0, 3) == 0) ? av : W'($urandom);
            if ($urandom_range(0, 3) == 0) bv = av ^ (W'(1) << $urandom_range(0, W - 1));
            check_run("random", 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), av, bv, -1);
        end
    endtask

    task automatic test_start_in_run();
        check_run("restart_run5", 3'd2, 2'd1, 16'hFFFE, 16'h0005, 5);
        check_run("restart_run9", 3'd0, 2'd0, 16'hABCD, 16'hABCD, 9);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, b1, a2, b2;
        int busy_low;
        a1 = 16'h1234; b1 = 16'h1234; a2 = 16'h0001; b2 = 16'h0000;
        busy_low = 0;
        start = 1'b1; op = 3'd0; dst = 2'd0; a_bit = a1[0]; b_bit = b1[0];
        for (int k = 1; k <= 2 * W; k++) begin
            next_cycle();
            start = 1'b0;
            if (busy !== 1'b1) busy_low++;
            if (k == W) begin
                vectors++;
                if (wr_en !== 1'b1 || q !== 2'd0 || data !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b first write: got wr %b q %0d data %b want 1 0 1", wr_en, q, data);
                end
                start = 1'b1; op = 3'd1; dst = 2'd2; a_bit = a2[0]; b_bit = b2[0];
            end else if (k == 2 * W) begin
                vectors++;
                if (wr_en !== 1'b1 || q !== 2'd2 || data !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b second write: got wr %b q %0d data %b want 1 2 1", wr_en, q, data);
                end
                a_bit = 1'b0; b_bit = 1'b0;
            end else begin
                if (wr_en !== 1'b0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL b2b stray write at cycle %0d: got wr 1 want 0", k);
                end
                a_bit = (k < W) ? a1[k] : a2[k - W];
                b_bit = (k < W) ? b1[k] : b2[k - W];
            end
        end
        vectors++;
        if (busy_low !== 0) begin
            miscompares++;
            $display("FAIL b2b busy: got %0d low cycles want 0", busy_low);
        end
        next_cycle();
        vectors++;
        if (busy !== 1'b0 || wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b end: got busy %b wr %b want 0 0", busy, wr_en);
        end
    endtask

    task automatic test_reset_abort();
        logic [W-1:0] av;
        int bad;
        av = 16'h5A5A;
        bad = 0;
        start = 1'b1; op = 3'd0; dst = 2'd1; a_bit = av[0]; b_bit = av[0];
        for (int k = 1; k <= 7; k++) begin
            next_cycle();
            start = 1'b0;
            a_bit = av[k]; b_bit = av[k];
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL abort immediate: got busy %b wr %b want 0 0", busy, wr_en);
        end
        next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 2 * W; k++) begin
            next_cycle();
            if (busy !== 1'b0 || wr_en !== 1'b0) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL abort after release: got %0d active cycles want 0", bad);
        end
        vectors++;
        if (q !== 2'b00 || data !== 1'b0) begin
            miscompares++;
            $display("FAIL abort regs: got q %0d data %b want 0 0", q, data);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0; start = 1'b0; op = 3'd0; dst = 2'd0; a_bit = 1'b0; b_bit = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        test_reset();
        test_directed();
        test_random();
        test_start_in_run();
        test_back_to_back();
        test_reset_abort();
        check_run("after_abort", 3'd5, 2'd2, 16'h0010, 16'h0100, -1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
